skinny_sbox8_serial: RTL and testbench
======================================

SKINNY_SBOX8_SERIAL -- requirements
Module: skinny_sbox8_serial

Interface
REQ-001 SHALL have parameter UNROLL, default 1: rounds computed per clock; legal values 1, 2, 4; any other value SHALL be a elaboration-time error.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port si  input  8  input byte, bit 7 = x7 (MSB).
REQ-005 SHALL have port inv  input  1  mode: 0 = forward SKINNY-128 8-bit S-box, 1 = inverse S-box; sampled with si.
REQ-006 SHALL have port si_valid  input  1  si/inv are valid.
REQ-007 SHALL have port si_ready  output  1  block can accept si.
REQ-008 SHALL have port so  output  8  result byte.
REQ-009 SHALL have port so_valid  output  1  so holds a completed result.
REQ-010 SHALL have port so_ready  input  1  consumer accepts so.

Function
REQ-011 Nonlinear step NL SHALL be: x4 ^= NOT(x7 OR x6); x0 ^= NOT(x3 OR x2); other bits unchanged (NL is its own inverse).
REQ-012 P1 SHALL map (x7..x0) -> (x2,x1,x7,x6,x4,x0,x3,x5); P2 SHALL map (x7..x0) -> (x7,x6,x5,x4,x3,x1,x2,x0).
REQ-013 Forward round r (r = 0..3) SHALL be NL then P1 for r<3, NL then P2 for r=3.
REQ-014 Inverse round r SHALL be: r=0 undo P2 then NL; r=1..3 undo P1 then NL; undo P1 maps (y7..y0) -> (y5,y4,y0,y3,y1,y7,y6,y2).
REQ-015 FSM states SHALL be IDLE, RUN, DONE; si_ready SHALL be 1 only in IDLE; so_valid SHALL be 1 only in DONE.
REQ-016 In IDLE, on an edge with si_valid=1: state register <= si, mode register <= inv, round counter <= 0, go to RUN; si_valid=0 keeps IDLE with registers unchanged.
REQ-017 In RUN, each edge SHALL apply UNROLL consecutive rounds (indices counter..counter+UNROLL-1) of the latched mode and advance counter by UNROLL modulo 4.
REQ-018 The RUN edge that completes round 3 SHALL move to DONE; latency from acceptance edge to so_valid rising SHALL be exactly 4/UNROLL edges.
REQ-019 so SHALL equal the state register at all times; it SHALL hold stable throughout DONE.
REQ-020 In DONE, so_ready=1 on an edge SHALL move to IDLE; so_ready=0 SHALL hold DONE and so indefinitely (backpressure).
REQ-021 No input SHALL be accepted in RUN or DONE; si_valid there SHALL be ignored and SHALL not alter state; a new transfer needs IDLE (no same-edge pass-through from DONE).
REQ-022 inv or si changing during RUN/DONE SHALL not affect the result.
REQ-023 Result SHALL be bit-exact: forward S(si) per SKINNY-128 table; inverse Sinv with Sinv(S(x)) = x for all 256 x.

Reset
REQ-024 rst=1 on an edge SHALL force IDLE, state register 0x00, mode 0, counter 0, hence so=0x00, so_valid=0, si_ready=1 after that edge.
REQ-025 rst SHALL take priority over every other input in any state, including mid-RUN and DONE; the aborted operation SHALL produce no so_valid.
REQ-026 First acceptance SHALL be possible on the first edge with rst=0.

Verification
REQ-027 Forward spot values, so_ready=1: si=0x00 -> so=0x65; si=0x01 -> 0x4C; si=0xFF -> 0xFF; so_valid rises exactly 4/UNROLL edges after acceptance.
REQ-028 Inverse spot values: si=0x65,inv=1 -> 0x00; si=0x4C -> 0x01; si=0xFF -> 0xFF.
REQ-029 Exhaustive sweep, all 256 inputs in both modes, for UNROLL=1,2,4: forward output matches the combinational reference S-box table; inverse(forward(x)) = x; mismatch count 0.
REQ-030 Backpressure: hold so_ready=0 for 10 cycles in DONE while toggling si_valid/si/inv -> so, so_valid=1, si_ready=0 stable; release -> IDLE next edge, next input accepted the edge after.
REQ-031 Reset mid-op: accept si=0x00, assert rst on the 2nd RUN edge (UNROLL=1) -> after that edge so=0x00, so_valid=0, si_ready=1; a following si=0x00 yields 0x65.

Source files
------------

// File: rtl/skinny_sbox8_serial_if.sv
// skinny_sbox8_serial_if: valid/ready byte handshake for the serial SKINNY-128 S-box
interface skinny_sbox8_serial_if;
    logic [7:0] si;
    logic       inv;
    logic       si_valid;
    logic       si_ready;
    logic [7:0] so;
    logic       so_valid;
    logic       so_ready;
    modport master (output si, inv, si_valid, so_ready, input si_ready, so, so_valid);
    modport slave (input si, inv, si_valid, so_ready, output si_ready, so, so_valid);
endinterface

// File: rtl/skinny_sbox8_serial.sv
// skinny_sbox8_serial: SKINNY-128 8-bit S-box and its inverse, UNROLL rounds per clock
module skinny_sbox8_serial #(
    parameter int UNROLL = 1
) (
    input logic clk,
    input logic rst,
    skinny_sbox8_serial_if.slave bus
);
    if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4) begin : g_bad_unroll
        $error("skinny_sbox8_serial: UNROLL must be 1, 2 or 4");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t     state, state_nx;
    logic [7:0] st;
    logic       md;
    logic [1:0] cnt;
    logic [2:0] cnt_sum;
    logic [7:0] chain [UNROLL+1];

    function automatic logic [7:0] nl(input logic [7:0] x);
        return {x[7:5], x[4] ^ ~(x[7] | x[6]), x[3:1], x[0] ^ ~(x[3] | x[2])};
    endfunction

    // inverse rounds run in index order 0..3: round 0 undoes P2, the rest undo P1
    function automatic logic [7:0] rnd(input logic [7:0] x, input logic [1:0] r, input logic iv);
        logic [7:0] n, u;
        n = nl(x);
        u = r == 2'd0 ? {x[7:3], x[1], x[2], x[0]} : {x[5], x[4], x[0], x[3], x[1], x[7], x[6], x[2]};
        return iv ? nl(u) : r == 2'd3 ? {n[7:3], n[1], n[2], n[0]}
                                      : {n[2], n[1], n[7], n[6], n[4], n[0], n[3], n[5]};
    endfunction

    assign chain[0] = st;
    for (genvar i = 0; i < UNROLL; i++) begin : g_round
        assign chain[i+1] = rnd(chain[i], cnt + 2'(i), md);
    end

    assign cnt_sum = {1'b0, cnt} + 3'(UNROLL);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            st    <= '0;
            md    <= 1'b0;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && bus.si_valid) begin
                st  <= bus.si;
                md  <= bus.inv;
                cnt <= '0;
            end else if (state == RUN) begin
                st  <= chain[UNROLL];
                cnt <= cnt_sum[1:0];
            end
        end
    end

    always_comb begin
        state_nx = state == IDLE ? (bus.si_valid ? RUN : IDLE)
                 : state == RUN  ? (cnt_sum[2] ? DONE : RUN)
                 : (bus.so_ready ? IDLE : DONE);
    end

    always_comb begin
        bus.si_ready = state == IDLE;
        bus.so_valid = state == DONE;
        bus.so       = st;
    end
endmodule

// File: tb/tb_skinny_sbox8_serial.sv
// tb_skinny_sbox8_serial: drives UNROLL=1,2,4 instances in lockstep against a bitmask S-box model
module tb_skinny_sbox8_serial;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] si = '0;
    logic       inv = 1'b0;
    logic       si_valid = 1'b0;
    logic       so_ready = 1'b0;
    logic [7:0] so [3];
    logic       so_valid [3];
    logic       si_ready [3];
    int         n_tests = 0;
    int         n_fail = 0;
    logic [7:0] exp_q [$];
    logic [7:0] sinv [256];
    logic [7:0] w;

    always #5 clk = ~clk;

    skinny_sbox8_serial_if b [3] ();

    for (genvar k = 0; k < 3; k++) begin : g_dut
        assign b[k].si       = si;
        assign b[k].inv      = inv;
        assign b[k].si_valid = si_valid;
        assign b[k].so_ready = so_ready;
        assign so[k]         = b[k].so;
        assign so_valid[k]   = b[k].so_valid;
        assign si_ready[k]   = b[k].si_ready;
        skinny_sbox8_serial #(.UNROLL(1 << k)) dut (.clk(clk), .rst(rst), .bus(b[k]));
    end

    function automatic logic [7:0] mix(input logic [7:0] x);
        return (~(((x >> 1) | x) >> 2) & 8'h11) ^ x;
    endfunction

    function automatic logic [7:0] perm(input logic [7:0] x);
        return ((x & 8'h01) << 2) | ((x & 8'h06) << 5) | ((x & 8'h20) >> 5) | ((x & 8'hC8) >> 2) | ((x & 8'h10) >> 1);
    endfunction

    function automatic logic [7:0] swp(input logic [7:0] x);
        return (x & 8'hF9) | ((x >> 1) & 8'h02) | ((x << 1) & 8'h04);
    endfunction

    function automatic logic [7:0] sref(input logic [7:0] x);
        return swp(mix(perm(mix(perm(mix(perm(mix(x))))))));
    endfunction

    task automatic check(input string tag, input int k, input logic [7:0] got, input logic [7:0] want);
        n_tests++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s U=%0d: observed %02h expected %02h", tag, 1 << k, got, want);
        end
    endtask

    task automatic check_flags(input string tag, input logic sv, input logic sr);
        for (int k = 0; k < 3; k++) begin
            check({tag, " so_valid"}, k, {7'b0, so_valid[k]}, {7'b0, sv});
            check({tag, " si_ready"}, k, {7'b0, si_ready[k]}, {7'b0, sr});
        end
    endtask

    task automatic run(input logic [7:0] x, input logic iv, input logic [7:0] want, input string tag);
        int lat [3];
        logic [7:0] e;
        lat = '{0, 0, 0};
        si = x;
        inv = iv;
        si_valid = 1'b1;
        so_ready = 1'b0;
        exp_q.push_back(want);
        @(posedge clk); #1;
        for (int c = 1; c <= 8 && (lat[0] == 0 || lat[1] == 0 || lat[2] == 0); c++) begin
            si = 8'($urandom);
            inv = 1'($urandom);
            si_valid = 1'($urandom);
            @(posedge clk); #1;
            for (int k = 0; k < 3; k++) if (so_valid[k] && lat[k] == 0) lat[k] = c;
        end
        si_valid = 1'b0;
        e = exp_q.pop_front();
        for (int k = 0; k < 3; k++) begin
            check({tag, " latency"}, k, 8'(lat[k]), 8'(4 >> k));
            check({tag, " so"}, k, so[k], e);
        end
        so_ready = 1'b1;
        @(posedge clk); #1;
        so_ready = 1'b0;
        check_flags({tag, " release"}, 1'b0, 1'b1);
    endtask

    initial begin
        for (int x = 0; x < 256; x++) sinv[sref(8'(x))] = 8'(x);
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) check("reset so", k, so[k], 8'h00);
        check_flags("reset", 1'b0, 1'b1);
        rst = 1'b0;
        run(8'h00, 1'b0, 8'h65, "fwd 00");
        run(8'h01, 1'b0, 8'h4C, "fwd 01");
        run(8'hFF, 1'b0, 8'hFF, "fwd FF");
        run(8'h65, 1'b1, 8'h00, "inv 65");
        run(8'h4C, 1'b1, 8'h01, "inv 4C");
        run(8'hFF, 1'b1, 8'hFF, "inv FF");

        si = 8'h01;
        inv = 1'b0;
        si_valid = 1'b1;
        exp_q.push_back(8'h4C);
        @(posedge clk); #1;
        si_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        w = exp_q.pop_front();
        for (int c = 0; c < 10; c++) begin
            si = 8'($urandom);
            inv = 1'($urandom);
            si_valid = 1'($urandom);
            @(posedge clk); #1;
            for (int k = 0; k < 3; k++) check("backpressure so", k, so[k], w);
            check_flags("backpressure", 1'b1, 1'b0);
        end
        si = 8'h00;
        inv = 1'b0;
        si_valid = 1'b1;
        so_ready = 1'b1;
        exp_q.push_back(8'h65);
        @(posedge clk); #1;
        so_ready = 1'b0;
        check_flags("bp release", 1'b0, 1'b1);
        @(posedge clk); #1;
        si_valid = 1'b0;
        check_flags("bp accept", 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        w = exp_q.pop_front();
        for (int k = 0; k < 3; k++) check("bp next so", k, so[k], w);
        check_flags("bp next", 1'b1, 1'b0);
        so_ready = 1'b1;
        @(posedge clk); #1;
        so_ready = 1'b0;

        si = 8'h00;
        inv = 1'b0;
        si_valid = 1'b1;
        @(posedge clk); #1;
        si_valid = 1'b0;
        @(posedge clk); #1;
        check("abort pre so_valid", 0, {7'b0, so_valid[0]}, 8'h00);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) check("abort so", k, so[k], 8'h00);
        check_flags("abort", 1'b0, 1'b1);
        run(8'h00, 1'b0, 8'h65, "post abort");

        for (int x = 0; x < 256; x++) run(8'(x), 1'b0, sref(8'(x)), "sweep fwd");
        for (int x = 0; x < 256; x++) run(8'(x), 1'b1, sinv[x], "sweep inv");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
